// File: rtl/wb_pkg.sv
// Shared Wishbone types and helpers for the core-bus interconnect.
package wb_pkg;

    localparam int WB_XLEN = 32;

    typedef logic [WB_XLEN/8-1:0] wb_sel_t;

    typedef enum logic [0:0] {
        WB_ARB_IDLE = 1'b0,
        WB_ARB_BUSY = 1'b1
    } wb_arb_state_e;

    // Index width that stays at least one bit wide for single-entry vectors.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin selector: first set request strictly after
// last_idx, wrapping modulo N.
module wb_rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_idx,
    output logic [IDX_W-1:0] sel,
    output logic             valid
);

    logic [IDX_W-1:0] w_idx;

    always_comb begin
        sel   = '0;
        valid = 1'b0;
        w_idx = last_idx;
        for (int i = 0; i < N; i++) begin
            w_idx = (w_idx == IDX_W'(N - 1)) ? '0 : w_idx + 1'b1;
            if (!valid && req[w_idx]) begin
                sel   = w_idx;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// N-master to 1-slave Wishbone classic arbiter, round-robin, grant held per CYC.
// Optional stall timeout with per-master error pulse: define WB_ARBITER_TIMEOUT_EN.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int XLEN           = WB_XLEN,
    parameter int NUM_MASTERS    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_MASTERS*XLEN-1:0]   m_adr,
    input  logic [NUM_MASTERS*XLEN-1:0]   m_dat_w,
    input  logic [NUM_MASTERS*XLEN/8-1:0] m_sel,
    input  logic [NUM_MASTERS-1:0]        m_we,
    input  logic [NUM_MASTERS-1:0]        m_stb,
    input  logic [NUM_MASTERS-1:0]        m_cyc,
    output logic [XLEN-1:0]               m_dat_r,
    output logic [NUM_MASTERS-1:0]        m_ack,
    output logic [NUM_MASTERS-1:0]        m_err,
    output logic [XLEN-1:0]               s_adr,
    output logic [XLEN-1:0]               s_dat_w,
    output logic [XLEN/8-1:0]             s_sel,
    output logic                          s_we,
    output logic                          s_stb,
    output logic                          s_cyc,
    input  logic [XLEN-1:0]               s_dat_r,
    input  logic                          s_ack,
    output logic [NUM_MASTERS-1:0]        gnt
);

    localparam int IDX_W = clog2_min1(NUM_MASTERS);
    localparam int SEL_W = XLEN / 8;

    wb_arb_state_e    r_state;
    logic [IDX_W-1:0] r_gnt_idx;
    logic [IDX_W-1:0] r_last_idx;
    logic [IDX_W-1:0] w_pick_idx;
    logic             w_pick_valid;
    logic             w_busy;

    logic [XLEN-1:0]  w_adr_arr   [NUM_MASTERS];
    logic [XLEN-1:0]  w_dat_w_arr [NUM_MASTERS];
    logic [SEL_W-1:0] w_sel_arr   [NUM_MASTERS];

    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
        assign w_adr_arr[gi]   = m_adr[gi*XLEN +: XLEN];
        assign w_dat_w_arr[gi] = m_dat_w[gi*XLEN +: XLEN];
        assign w_sel_arr[gi]   = m_sel[gi*SEL_W +: SEL_W];
    end

    wb_rr_pick #(
        .N     (NUM_MASTERS),
        .IDX_W (IDX_W)
    ) u_pick (
        .req      (m_cyc),
        .last_idx (r_last_idx),
        .sel      (w_pick_idx),
        .valid    (w_pick_valid)
    );

    assign w_busy  = (r_state == WB_ARB_BUSY);
    assign m_dat_r = s_dat_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= WB_ARB_IDLE;
            r_gnt_idx  <= '0;
            r_last_idx <= IDX_W'(NUM_MASTERS - 1);
        end else if (!w_busy) begin
            if (w_pick_valid) begin
                r_gnt_idx  <= w_pick_idx;
                r_last_idx <= w_pick_idx;
                r_state    <= WB_ARB_BUSY;
            end
        end else if (!m_cyc[r_gnt_idx]) begin
            r_state <= WB_ARB_IDLE;
        end
    end

    // The datapath is a pure mux, so a master dropping CYC releases the slave in the same cycle.
    always_comb begin
        s_adr   = '0;
        s_dat_w = '0;
        s_sel   = '0;
        s_we    = 1'b0;
        s_stb   = 1'b0;
        s_cyc   = 1'b0;
        m_ack   = '0;
        gnt     = '0;
        if (w_busy) begin
            s_adr            = w_adr_arr[r_gnt_idx];
            s_dat_w          = w_dat_w_arr[r_gnt_idx];
            s_sel            = w_sel_arr[r_gnt_idx];
            s_we             = m_we[r_gnt_idx];
            s_stb            = m_stb[r_gnt_idx];
            s_cyc            = m_cyc[r_gnt_idx];
            m_ack[r_gnt_idx] = s_ack;
            gnt[r_gnt_idx]   = 1'b1;
        end
    end

`ifdef WB_ARBITER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            w_to_hit;

    assign w_to_hit = w_busy && (r_to_cnt == TO_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if (!w_busy || s_ack || w_to_hit) begin
            r_to_cnt <= '0;
        end else if (s_stb) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // Error is flagged but the grant is kept; the master is expected to drop CYC.
    always_comb begin
        m_err = '0;
        if (w_to_hit) begin
            m_err[r_gnt_idx] = 1'b1;
        end
    end
`else
    assign m_err = '0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter (3 masters) with a round-robin reference model.
module tb_wb_arbiter;

    localparam int XLEN = 32;
    localparam int NM   = 3;
    localparam int SW   = XLEN / 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NM*XLEN-1:0] m_adr, m_dat_w;
    logic [NM*SW-1:0]  m_sel;
    logic [NM-1:0]     m_we, m_stb, m_cyc;
    logic [XLEN-1:0]   m_dat_r;
    logic [NM-1:0]     m_ack, m_err, gnt;
    logic [XLEN-1:0]   s_adr, s_dat_w, s_dat_r;
    logic [SW-1:0]     s_sel;
    logic              s_we, s_stb, s_cyc, s_ack;

    logic [XLEN-1:0]   ma_adr [NM];
    logic [XLEN-1:0]   ma_dat [NM];
    logic [SW-1:0]     ma_sel [NM];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: current owner (-1 when idle) and last master served.
    int exp_owner;
    int exp_last;

    for (genvar gi = 0; gi < NM; gi++) begin : g_pack
        assign m_adr[gi*XLEN +: XLEN] = ma_adr[gi];
        assign m_dat_w[gi*XLEN +: XLEN] = ma_dat[gi];
        assign m_sel[gi*SW +: SW] = ma_sel[gi];
    end

    always #5 clk = ~clk;

    wb_arbiter #(
        .XLEN           (XLEN),
        .NUM_MASTERS    (NM),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .m_adr   (m_adr),
        .m_dat_w (m_dat_w),
        .m_sel   (m_sel),
        .m_we    (m_we),
        .m_stb   (m_stb),
        .m_cyc   (m_cyc),
        .m_dat_r (m_dat_r),
        .m_ack   (m_ack),
        .m_err   (m_err),
        .s_adr   (s_adr),
        .s_dat_w (s_dat_w),
        .s_sel   (s_sel),
        .s_we    (s_we),
        .s_stb   (s_stb),
        .s_cyc   (s_cyc),
        .s_dat_r (s_dat_r),
        .s_ack   (s_ack),
        .gnt     (gnt)
    );

    function automatic int rr_next(input logic [NM-1:0] req, input int last);
        for (int k = 1; k <= NM; k++) begin
            if (req[(last + k) % NM]) return (last + k) % NM;
        end
        return -1;
    endfunction

    task automatic model_reset();
        exp_owner = -1;
        exp_last  = NM - 1;
    endtask

    task automatic model_step();
        int p;
        if (exp_owner < 0) begin
            p = rr_next(m_cyc, exp_last);
            if (p >= 0) begin
                exp_owner = p;
                exp_last  = p;
            end
        end else if (!m_cyc[exp_owner]) begin
            exp_owner = -1;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        s_ack = 1'b0;
        #7;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        m_cyc = 3'b111;
        m_stb = 3'b111;
        s_ack = 1'b1;
        #12;
        n_checks++; if (s_cyc !== 1'b0) begin n_fail++; $display("FAIL reset_s_cyc got %b want 0", s_cyc); end
        n_checks++; if (gnt !== 3'b000) begin n_fail++; $display("FAIL reset_gnt got %b want 000", gnt); end
        n_checks++; if (m_ack !== 3'b000) begin n_fail++; $display("FAIL reset_m_ack got %b want 000", m_ack); end
        n_checks++; if (m_err !== 3'b000) begin n_fail++; $display("FAIL reset_m_err got %b want 000", m_err); end
        s_ack = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        tick();
        n_checks++; if (gnt !== 3'b001) begin n_fail++; $display("FAIL reset_first_gnt got %b want 001", gnt); end
        $display("txn reset: first grant %b", gnt);
        m_cyc = '0;
        m_stb = '0;
        tick();
        tick();
    endtask

    task automatic test_single_read();
        ma_adr[0] = 32'h0000_1000;
        m_we[0]   = 1'b0;
        m_cyc[0]  = 1'b1;
        m_stb[0]  = 1'b1;
        #1;
        n_checks++; if (s_cyc !== 1'b0) begin n_fail++; $display("FAIL read_latency0 s_cyc got %b want 0", s_cyc); end
        tick();
        n_checks++; if (s_cyc !== 1'b1) begin n_fail++; $display("FAIL read_latency1 s_cyc got %b want 1", s_cyc); end
        n_checks++; if (s_adr !== 32'h0000_1000) begin n_fail++; $display("FAIL read_s_adr got %h want 00001000", s_adr); end
        s_ack   = 1'b1;
        s_dat_r = 32'hDEAD_BEEF;
        #1;
        n_checks++; if (m_ack !== 3'b001) begin n_fail++; $display("FAIL read_m_ack got %b want 001", m_ack); end
        n_checks++; if (m_dat_r !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL read_m_dat_r got %h want deadbeef", m_dat_r); end
        $display("txn read m0 adr=%h dat=%h", s_adr, m_dat_r);
        tick();
        s_ack    = 1'b0;
        m_cyc[0] = 1'b0;
        m_stb[0] = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_round_robin();
        int order [4] = '{0, 1, 2, 0};
        logic [NM-1:0] want;
        do_reset();
        m_cyc = 3'b111;
        m_stb = 3'b111;
        for (int k = 0; k < 4; k++) begin
            want = '0;
            want[order[k]] = 1'b1;
            tick();
            n_checks++; if (gnt !== want) begin n_fail++; $display("FAIL rr_gnt[%0d] got %b want %b", k, gnt, want); end
            s_ack = 1'b1;
            #1;
            n_checks++; if (m_ack !== want) begin n_fail++; $display("FAIL rr_ack[%0d] got %b want %b", k, m_ack, want); end
            $display("txn rr burst %0d master %0d", k, order[k]);
            tick();
            s_ack = 1'b0;
            m_cyc[order[k]] = 1'b0;
            #1;
            n_checks++; if (s_cyc !== 1'b0) begin n_fail++; $display("FAIL rr_drop_s_cyc[%0d] got %b want 0", k, s_cyc); end
            tick();
            n_checks++; if (s_cyc !== 1'b0 || gnt !== 3'b000) begin n_fail++; $display("FAIL rr_dead[%0d] got s_cyc=%b gnt=%b want 0/000", k, s_cyc, gnt); end
            if (k < 3) m_cyc[order[k]] = 1'b1;
        end
    endtask

    task automatic test_burst_hold();
        m_cyc     = 3'b111;
        m_stb     = 3'b111;
        m_we      = 3'b010;
        ma_sel[1] = 4'b0011;
        tick();
        for (int k = 0; k < 4; k++) begin
            ma_adr[1] = $urandom;
            ma_dat[1] = $urandom;
            s_ack = 1'b1;
            #1;
            n_checks++; if (gnt !== 3'b010) begin n_fail++; $display("FAIL burst_gnt[%0d] got %b want 010", k, gnt); end
            n_checks++; if (s_we !== 1'b1 || s_sel !== 4'b0011) begin n_fail++; $display("FAIL burst_we_sel[%0d] got %b/%b want 1/0011", k, s_we, s_sel); end
            n_checks++; if (s_adr !== ma_adr[1] || s_dat_w !== ma_dat[1]) begin n_fail++; $display("FAIL burst_adr_dat[%0d] got %h/%h want %h/%h", k, s_adr, s_dat_w, ma_adr[1], ma_dat[1]); end
            n_checks++; if (m_ack !== 3'b010) begin n_fail++; $display("FAIL burst_ack[%0d] got %b want 010", k, m_ack); end
            $display("txn write m1 adr=%h dat=%h", s_adr, s_dat_w);
            tick();
        end
        s_ack    = 1'b0;
        m_cyc[1] = 1'b0;
        m_we     = '0;
        tick();
        tick();
        n_checks++; if (gnt !== 3'b100) begin n_fail++; $display("FAIL burst_next_gnt got %b want 100", gnt); end
    endtask

    task automatic test_async_reset();
        s_ack = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++; if (s_cyc !== 1'b0 || gnt !== 3'b000) begin n_fail++; $display("FAIL async_rst got s_cyc=%b gnt=%b want 0/000", s_cyc, gnt); end
        n_checks++; if (m_ack !== 3'b000) begin n_fail++; $display("FAIL async_rst_ack got %b want 000", m_ack); end
        s_ack = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        tick();
        n_checks++; if (gnt !== 3'b001) begin n_fail++; $display("FAIL async_rst_regnt got %b want 001", gnt); end
        $display("txn async reset: regrant %b", gnt);
        m_cyc = '0;
        m_stb = '0;
        tick();
        tick();
    endtask

    task automatic test_random();
        logic [NM-1:0]   e_gnt, e_ack;
        logic [XLEN-1:0] e_adr;
        logic            e_cyc, e_stb, e_we;
        int e;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NM; i++) begin
                if (!m_cyc[i]) m_cyc[i] = ($urandom_range(0, 2) == 0);
                else           m_cyc[i] = ($urandom_range(0, 3) != 0);
                m_stb[i]  = m_cyc[i] & $urandom_range(0, 1);
                m_we[i]   = $urandom_range(0, 1);
                ma_adr[i] = $urandom;
                ma_dat[i] = $urandom;
                ma_sel[i] = SW'($urandom);
            end
            s_ack   = $urandom_range(0, 1);
            s_dat_r = $urandom;
            #1;
            e = exp_owner;
            e_gnt = '0; e_ack = '0; e_adr = '0; e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0;
            if (e >= 0) begin
                e_gnt[e] = 1'b1;
                e_ack[e] = s_ack;
                e_adr = ma_adr[e];
                e_cyc = m_cyc[e];
                e_stb = m_stb[e];
                e_we  = m_we[e];
            end
            n_checks++; if (gnt !== e_gnt) begin n_fail++; $display("FAIL rand_gnt@%0d got %b want %b", c, gnt, e_gnt); end
            n_checks++; if (m_ack !== e_ack) begin n_fail++; $display("FAIL rand_ack@%0d got %b want %b", c, m_ack, e_ack); end
            n_checks++; if (s_adr !== e_adr) begin n_fail++; $display("FAIL rand_adr@%0d got %h want %h", c, s_adr, e_adr); end
            n_checks++; if ({s_cyc, s_stb, s_we} !== {e_cyc, e_stb, e_we}) begin n_fail++; $display("FAIL rand_ctl@%0d got %b want %b", c, {s_cyc, s_stb, s_we}, {e_cyc, e_stb, e_we}); end
            n_checks++; if (m_dat_r !== s_dat_r) begin n_fail++; $display("FAIL rand_dat_r@%0d got %h want %h", c, m_dat_r, s_dat_r); end
            if (e >= 0 && s_ack && m_cyc[e] && m_stb[e])
                $display("txn rand m%0d we=%b adr=%h", e, m_we[e], ma_adr[e]);
            tick();
        end
        m_cyc = '0;
        m_stb = '0;
        s_ack = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_timeout();
        logic [NM-1:0] want;
        do_reset();
        m_cyc[0] = 1'b1;
        m_stb[0] = 1'b1;
        s_ack    = 1'b0;
        tick();
        for (int c = 1; c <= 12; c++) begin
`ifdef WB_ARBITER_TIMEOUT_EN
            want = (c == 9) ? 3'b001 : 3'b000;
`else
            want = 3'b000;
`endif
            n_checks++; if (m_err !== want) begin n_fail++; $display("FAIL timeout_err@%0d got %b want %b", c, m_err, want); end
            tick();
        end
        $display("txn timeout stall m0 done");
        m_cyc = '0;
        m_stb = '0;
        tick();
        tick();
    endtask

    initial begin
        m_cyc = '0; m_stb = '0; m_we = '0;
        s_ack = 1'b0; s_dat_r = '0;
        for (int i = 0; i < NM; i++) begin
            ma_adr[i] = '0; ma_dat[i] = '0; ma_sel[i] = '0;
        end
        model_reset();
        test_reset();
        test_single_read();
        test_round_robin();
        test_burst_hold();
        test_async_reset();
        test_random();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
